// File: rtl/fifo_ctrl4x64_pkg.sv
// fifo_ctrl4x64_pkg: shared depth, pointer width, default word width and occupancy state enum
package fifo_ctrl4x64_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W = 3;
  localparam int DEF_DATA_W = 64;
  typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL} state_t;
endpackage

// File: rtl/fifo_ctrl4x64_if.sv
// fifo_ctrl4x64_if: push (in_valid/in_data/in_ready) and pop (out_valid/out_data/out_ready) handshake; master = producer/consumer side, slave = fifo
interface fifo_ctrl4x64_if #(parameter int DATA_W = fifo_ctrl4x64_pkg::DEF_DATA_W);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/fifo_ctrl4x64_ptr.sv
// fifo_ptr: 3-bit wrap counter; clk/rst async reset, clr sync clear, inc increment enable, ptr count out
module fifo_ptr
  import fifo_ctrl4x64_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl4x64.sv
// fifo_ctrl4x64: 4x64 fifo pointer/flag controller; s = push/pop handshake, flush sync clear, count/flags occupancy, w_*/r_* external storage port
module fifo_ctrl4x64
  import fifo_ctrl4x64_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AFULL_LVL = 3,
  parameter int AEMPTY_LVL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  fifo_ctrl4x64_if.slave    s,
  output logic [PTR_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [1:0]        w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              w_enable,
  output logic [1:0]        r_addr,
  input  logic [DATA_W-1:0] r_data
);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  state_t state, next_state;
  fifo_ptr u_wr (.clk(clk), .rst(rst), .clr(flush), .inc(push), .ptr(wr_ptr));
  fifo_ptr u_rd (.clk(clk), .rst(rst), .clr(flush), .inc(pop), .ptr(rd_ptr));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_EMPTY;
    else state <= next_state;
  always_comb begin
    next_state = flush ? S_EMPTY
               : (push && !pop) ? ((count == PTR_W'(FIFO_DEPTH - 1)) ? S_FULL : S_PART)
               : (pop && !push) ? ((count == PTR_W'(1)) ? S_EMPTY : S_PART)
               : state;
  end
  assign count = wr_ptr - rd_ptr;
  assign full = state == S_FULL;
  assign empty = state == S_EMPTY;
  assign almost_full = count >= PTR_W'(AFULL_LVL);
  assign almost_empty = count <= PTR_W'(AEMPTY_LVL);
  assign s.in_ready = !full && !flush;
  assign s.out_valid = !empty && !flush;
  assign push = s.in_valid && s.in_ready;
  assign pop = s.out_valid && s.out_ready;
  assign w_enable = push;
  assign w_addr = wr_ptr[1:0];
  assign w_data = s.in_data;
  assign r_addr = rd_ptr[1:0];
  assign s.out_data = r_data;
endmodule

// File: tb/tb_fifo_ctrl4x64.sv
// tb_fifo_ctrl4x64: directed self-checking bench for fifo_ctrl4x64 with a behavioural 4x64 storage model
module tb_fifo_ctrl4x64;
  logic clk = 0, rst = 1, flush = 0;
  logic [2:0] count;
  logic full, empty, almost_full, almost_empty, w_enable;
  logic [1:0] w_addr, r_addr;
  logic [63:0] w_data, r_data;
  logic [63:0] mem [4];
  logic [63:0] q[$];
  int checks = 0, failures = 0;
  fifo_ctrl4x64_if #(.DATA_W(64)) bus ();
  fifo_ctrl4x64 dut (
    .clk(clk), .rst(rst), .flush(flush), .s(bus.slave),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .w_addr(w_addr), .w_data(w_data), .w_enable(w_enable),
    .r_addr(r_addr), .r_data(r_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (w_enable) mem[w_addr] <= w_data;
  assign r_data = mem[r_addr];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    #12 rst = 0;
    step();
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_aempty", 64'(almost_empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_afull", 64'(almost_full), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      chk("idle_wen", 64'(w_enable), 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1;
      bus.in_data = 64'hA0 + 64'(i);
      #1;
      chk("fill_waddr", 64'(w_addr), 64'(i));
      chk("fill_wen", 64'(w_enable), 1);
      step();
    end
    bus.in_data = 64'hFF;
    #1;
    chk("full_flag", 64'(full), 1);
    chk("full_in_ready", 64'(bus.in_ready), 0);
    chk("full_count", 64'(count), 4);
    chk("full_afull", 64'(almost_full), 1);
    chk("full_wen", 64'(w_enable), 0);
    step();
    chk("full_hold_count", 64'(count), 4);
    bus.in_valid = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("pop_valid", 64'(bus.out_valid), 1);
      chk("pop_data", bus.out_data, 64'hA0 + 64'(i));
      step();
    end
    bus.out_ready = 0;
    chk("drain_empty", 64'(empty), 1);
    chk("drain_out_valid", 64'(bus.out_valid), 0);
    chk("drain_count", 64'(count), 0);
    bus.in_valid = 1;
    bus.in_data = 64'hB0;
    #1;
    chk("wrap_waddr", 64'(w_addr), 0);
    chk("wrap_bit", 64'(dut.wr_ptr), 4);
    q.push_back(64'hB0);
    step();
    chk("latency_valid", 64'(bus.out_valid), 1);
    chk("latency_data", bus.out_data, 64'hB0);
    bus.in_data = 64'hB1;
    q.push_back(64'hB1);
    step();
    chk("stream_pre_count", 64'(count), 2);
    bus.out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 64'hC0 + 64'(i);
      #1;
      chk("stream_count", 64'(count), 2);
      chk("stream_data", bus.out_data, q[0]);
      void'(q.pop_front());
      q.push_back(64'hC0 + 64'(i));
      step();
    end
    chk("stream_waddr", 64'(w_addr), 0);
    chk("stream_raddr", 64'(r_addr), 2);
    bus.in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("tail_data", bus.out_data, q[0]);
      void'(q.pop_front());
      step();
    end
    bus.out_ready = 0;
    chk("tail_empty", 64'(empty), 1);
    bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 64'hD0 + 64'(i);
      step();
    end
    chk("pre_flush_count", 64'(count), 3);
    chk("pre_flush_afull", 64'(almost_full), 1);
    flush = 1;
    bus.in_data = 64'hDD;
    #1;
    chk("flush_wen", 64'(w_enable), 0);
    chk("flush_in_ready", 64'(bus.in_ready), 0);
    chk("flush_out_valid", 64'(bus.out_valid), 0);
    step();
    flush = 0;
    bus.in_valid = 0;
    #1;
    chk("post_flush_count", 64'(count), 0);
    chk("post_flush_out_valid", 64'(bus.out_valid), 0);
    chk("post_flush_empty", 64'(empty), 1);
    bus.in_valid = 1;
    bus.in_data = 64'hE5;
    #1;
    chk("post_flush_waddr", 64'(w_addr), 0);
    step();
    chk("post_flush_data", bus.out_data, 64'hE5);
    chk("post_flush_valid", 64'(bus.out_valid), 1);
    bus.in_data = 64'hE6;
    step();
    bus.in_valid = 0;
    chk("pre_rst_count", 64'(count), 2);
    #2 rst = 1;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_empty", 64'(empty), 1);
    chk("arst_out_valid", 64'(bus.out_valid), 0);
    chk("arst_raddr", 64'(r_addr), 0);
    chk("arst_waddr", 64'(w_addr), 0);
    step();
    rst = 0;
    step();
    chk("after_rst_count", 64'(count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl4x64.md
# fifo_ctrl4x64

Pointer-and-flag controller for the 4-entry × 64-bit FIFO in the buffering path. It accepts words on a valid/ready push port and drives the write address, write data and write enable of the 4×64 register storage. It also drives the storage read address and presents the storage read data on a valid/ready pop port. Occupancy flags go to upstream and downstream stages.

## Interface
- DATA_W, 64, word width; must match storage width
- AFULL_LVL, 3, count at or above which almost_full asserts
- AEMPTY_LVL, 1, count at or below which almost_empty asserts
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of the FIFO contents
- in_valid  in  1  push request
- in_data  in  DATA_W  push word
- in_ready  out  1  push accepted when in_valid && in_ready
- out_valid  out  1  head word available
- out_data  out  DATA_W  head word
- out_ready  in  1  pop accepted when out_valid && out_ready
- count  out  3  occupancy, 0..4
- full, empty, almost_full, almost_empty  out  1  occupancy flags
- w_addr  out  2  storage write address (write pointer)
- w_data  out  DATA_W  storage write data (equals in_data)
- w_enable  out  1  storage write strobe
- r_addr  out  2  storage read address (read pointer)
- r_data  in  DATA_W  storage read data (combinational from r_addr)

## Operation
- State: wr_ptr[2:0] and rd_ptr[2:0]. Bits [1:0] index storage; bit 2 is the wrap bit.
- count = wr_ptr − rd_ptr, modulo 8.
- State machine S_EMPTY / S_PART / S_FULL, derived from count:
  - S_EMPTY when count == 0
  - S_FULL when count == 4
  - S_PART otherwise
  - Legal transitions are only to adjacent states, or holding.
- in_ready = !full && !flush.
- out_valid = !empty && !flush.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- w_enable = push; w_addr = wr_ptr[1:0]; w_data = in_data.
- r_addr = rd_ptr[1:0]; out_data = r_data.
- On push, wr_ptr increments by 1. On pop, rd_ptr increments by 1. Both increments wrap 7→0.
- Simultaneous push and pop in S_PART: both pointers advance and count is unchanged.
- Push and pop cannot both occur in S_EMPTY or S_FULL, because one of in_ready/out_valid is low.
- flush: both pointers go to 0 at the next edge and no write strobe issues. flush overrides push and pop in the same cycle.
- Flags:
  - full = (count == 4); empty = (count == 0)
  - almost_full = (count >= AFULL_LVL); almost_empty = (count <= AEMPTY_LVL)
  - All flags are decoded from registered pointers only, never from same-cycle inputs.
- Storage contents are not cleared by flush. Stale entries are never presented, because out_valid is gated by count.

## Timing
- Reset values, asynchronous:
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - in_ready = 1 (when flush = 0), out_valid = 0, w_enable = 0
  - w_addr = 0, r_addr = 0
- Push-to-pop latency is 1 cycle. A word pushed at edge N is visible on out_data with out_valid = 1 in the cycle after edge N.
- out_data changes only after a pop edge, a reset, or a write into an empty FIFO.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Reset asserted mid-transfer: the transfer is discarded, pointers return to 0 immediately, and outputs take their reset values while rst is high.
- Throughput is one push and one pop per cycle in S_PART.

## Structure
- Shared package holds:
  - FIFO_DEPTH = 4, PTR_W = 3
  - State enum {S_EMPTY, S_PART, S_FULL}
  - Default DATA_W
- One sub-module is natural: fifo_ptr, a 3-bit wrap counter with increment enable, synchronous clear and asynchronous reset. It is instantiated twice, once for write and once for read.
- Storage is external. A top-level wrapper connects this block to the 4×64 register buffer.

## Test plan
- Reset, then idle → count = 0, empty = 1, in_ready = 1, out_valid = 0, w_enable never 1.
- Push 0xA0..0xA3 on consecutive cycles with out_ready = 0 → w_addr 0,1,2,3. After the 4th edge: full = 1, in_ready = 0, count = 4. A 5th in_valid is not accepted.
- Then pop 4 with out_ready = 1 → out_data 0xA0, 0xA1, 0xA2, 0xA3 in order, then empty = 1. Next push lands at w_addr 0 with wrap bit 1.
- Steady stream with count = 2 and push + pop every cycle for 10 cycles → count stays 2, pointers wrap through 7→0, and data order is preserved.
- Fill to 3, assert flush with in_valid = 1 → no write strobe. Next cycle count = 0, out_valid = 0, and the following push reads back correctly.
- Assert rst asynchronously mid-cycle with count = 2 → empty = 1, count = 0 before the next clock edge, out_valid = 0.
